// File: rtl/cpu_types_pkg.sv
// Shared cache/memory interface types: data word, memory status and the
// memory responder's FSM, source and latched-request types.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;

  typedef enum logic [1:0] {MEM_IDLE, MEM_BUSY, MEM_DONE, MEM_ERR} memfsm_t;

  typedef enum logic {SRC_I, SRC_D} memsrc_t;

  typedef struct packed {
    memsrc_t src;
    logic    wen;
    word_t   addr;
    word_t   data;
  } memreq_t;

  // Largest BUSY cycle count the 4-bit latency counter can reach.
  localparam int MEM_LAT_MAX = 15;

endpackage

// File: rtl/mem_arb.sv
// Request arbiter: dcache wins over icache. Flags a dcache read/write
// conflict or a misaligned selected address as an error.
module mem_arb
  import cpu_types_pkg::*;
(
  input  logic    iREN,
  input  word_t   iaddr,
  input  logic    dREN,
  input  logic    dWEN,
  input  word_t   daddr,
  input  word_t   dstore,
  output memreq_t req,
  output logic    valid,
  output logic    err
);

  logic dsel;

  // Pick the source, build the request and classify it.
  always_comb begin
    dsel     = dREN | dWEN;
    valid    = dsel | iREN;
    req.src  = dsel ? SRC_D : SRC_I;
    req.wen  = dsel & dWEN;
    req.addr = dsel ? daddr : iaddr;
    req.data = dstore;
    err      = valid & ((dREN & dWEN) | (req.addr[1:0] != 2'b00));
  end

endmodule

// File: rtl/cache_mem_responder.sv
// Memory end of the cache subsystem: word-addressed array serving one
// icache/dcache request at a time after LAT busy cycles, plus a backdoor
// write port for preloading.
module cache_mem_responder
  import cpu_types_pkg::*;
#(
  parameter int MEM_WORDS = 1024,
  parameter int LAT       = 2
) (
  input  logic      CLK,
  input  logic      RST,
  input  logic      iREN,
  input  word_t     iaddr,
  output word_t     iload,
  output logic      iwait,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output word_t     dload,
  output logic      dwait,
  output ramstate_t ramstate,
  input  logic      bd_wen,
  input  word_t     bd_addr,
  input  word_t     bd_data
);

  localparam int AW = $clog2(MEM_WORDS);

  word_t          mem [MEM_WORDS];
  memfsm_t        state, state_nx;
  logic [3:0]     cnt, cnt_nx;
  memreq_t        cur, cur_nx;
  word_t          iload_q, dload_q;
  memreq_t        arb_req;
  logic           arb_vld, arb_err;
  logic [AW-1:0]  cur_idx, bd_idx;
  logic           src_req, mem_we, rd_i, rd_d;
  logic           unused_addr_bits;

  mem_arb u_arb (
    .iREN   (iREN),
    .iaddr  (iaddr),
    .dREN   (dREN),
    .dWEN   (dWEN),
    .daddr  (daddr),
    .dstore (dstore),
    .req    (arb_req),
    .valid  (arb_vld),
    .err    (arb_err)
  );

  // Addresses wrap: only the word-index bits select a location.
  assign cur_idx          = cur.addr[AW+1:2];
  assign bd_idx           = bd_addr[AW+1:2];
  assign unused_addr_bits = ^{cur.addr[31:AW+2], cur.addr[1:0],
                              bd_addr[31:AW+2], bd_addr[1:0]};

  // Is the latched source still asserting its request?
  assign src_req = (cur.src == SRC_D) ? (dREN | dWEN) : iREN;

  // Next-state, status and wait generation.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    cur_nx   = cur;
    ramstate = FREE;
    iwait    = iREN;
    dwait    = dREN | dWEN;
    mem_we   = 1'b0;
    rd_i     = 1'b0;
    rd_d     = 1'b0;
    case (state)
      MEM_IDLE: begin
        if (arb_vld) begin
          cur_nx = arb_req;
          if (arb_err) begin
            state_nx = MEM_ERR;
          end else if (LAT == 0) begin
            state_nx = MEM_DONE;
          end else begin
            state_nx = MEM_BUSY;
            cnt_nx   = 4'd1;
          end
        end
      end
      MEM_BUSY: begin
        ramstate = BUSY;
        // A dropped request abandons the access even on the last busy cycle.
        if (!src_req) begin
          state_nx = MEM_IDLE;
          cnt_nx   = '0;
        end else if (cnt == 4'(LAT)) begin
          state_nx = MEM_DONE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 4'd1;
        end
      end
      MEM_DONE: begin
        ramstate = ACCESS;
        if (cur.src == SRC_D) dwait = 1'b0;
        else                  iwait = 1'b0;
        mem_we   = cur.wen;
        rd_i     = (cur.src == SRC_I) & ~cur.wen;
        rd_d     = (cur.src == SRC_D) & ~cur.wen;
        state_nx = MEM_IDLE;
      end
      MEM_ERR: begin
        ramstate = ERROR;
        dwait    = 1'b1;
        if (!src_req) state_nx = MEM_IDLE;
      end
      default: state_nx = MEM_IDLE;
    endcase
  end

  // Load buses show the array word during DONE and hold it afterwards.
  always_comb begin
    iload = rd_i ? mem[cur_idx] : iload_q;
    dload = rd_d ? mem[cur_idx] : dload_q;
  end

  // FSM, counter, latched request and held load data.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= MEM_IDLE;
      cnt     <= '0;
      cur     <= '0;
      iload_q <= '0;
      dload_q <= '0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      cur     <= cur_nx;
      iload_q <= iload;
      dload_q <= dload;
    end
  end

  // Array writes; the backdoor is ordered last so it wins a same-index clash.
  always_ff @(posedge CLK) begin
    if (mem_we && !RST) mem[cur_idx] <= cur.data;
    if (bd_wen)         mem[bd_idx]  <= bd_data;
  end

endmodule

// File: tb/tb_cache_mem_responder.sv
// Randomized bench for cache_mem_responder: one instance with LAT=2 and one
// with LAT=0, both checked against a transaction-level memory model.
module tb_cache_mem_responder;
  import cpu_types_pkg::*;

  logic      clk = 1'b0;
  logic      rst    [2];
  logic      iren   [2];
  logic      dren   [2];
  logic      dwen   [2];
  logic      bdw    [2];
  word_t     iaddr  [2];
  word_t     daddr  [2];
  word_t     dstore [2];
  word_t     bda    [2];
  word_t     bdd    [2];
  word_t     iload  [2];
  word_t     dload  [2];
  logic      iwait  [2];
  logic      dwait  [2];
  ramstate_t rs     [2];

  word_t mdl    [2][1024];
  word_t last_i [2];
  word_t last_d [2];
  int    n_chk  = 0;
  int    n_pass = 0;

  always #5 clk = ~clk;

  cache_mem_responder #(.MEM_WORDS(1024), .LAT(2)) u_lat2 (
    .CLK(clk), .RST(rst[0]), .iREN(iren[0]), .iaddr(iaddr[0]), .iload(iload[0]),
    .iwait(iwait[0]), .dREN(dren[0]), .dWEN(dwen[0]), .daddr(daddr[0]),
    .dstore(dstore[0]), .dload(dload[0]), .dwait(dwait[0]), .ramstate(rs[0]),
    .bd_wen(bdw[0]), .bd_addr(bda[0]), .bd_data(bdd[0]));

  cache_mem_responder #(.MEM_WORDS(1024), .LAT(0)) u_lat0 (
    .CLK(clk), .RST(rst[1]), .iREN(iren[1]), .iaddr(iaddr[1]), .iload(iload[1]),
    .iwait(iwait[1]), .dREN(dren[1]), .dWEN(dwen[1]), .daddr(daddr[1]),
    .dstore(dstore[1]), .dload(dload[1]), .dwait(dwait[1]), .ramstate(rs[1]),
    .bd_wen(bdw[1]), .bd_addr(bda[1]), .bd_data(bdd[1]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic int lat_of(input int u);
    return (u == 0) ? 2 : 0;
  endfunction

  function automatic int idx(input word_t a);
    return int'(a[11:2]);
  endfunction

  // Status expected k cycles after a request is captured in IDLE.
  function automatic logic [31:0] rs_exp(input int k, input int L);
    if (k == 0) return 32'(FREE);
    if (k <= L) return 32'(BUSY);
    return 32'(ACCESS);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr(input int u);
    iren[u] = 1'b0; dren[u] = 1'b0; dwen[u] = 1'b0; bdw[u] = 1'b0;
  endtask

  task automatic bd_write(input int u, input word_t a, input word_t d);
    bdw[u] = 1'b1; bda[u] = a; bdd[u] = d;
    step();
    bdw[u] = 1'b0;
    mdl[u][idx(a)] = d;
  endtask

  // One full request, optionally changing the bus mid-flight or colliding
  // with a backdoor write in the completion cycle.
  task automatic txn(input int u, input bit isd, input bit wen, input word_t addr,
                     input word_t data, input bit scramble, input bit collide,
                     input word_t bdata);
    int L = lat_of(u);
    iren[u] = !isd; dren[u] = isd & !wen; dwen[u] = isd & wen;
    iaddr[u] = addr; daddr[u] = addr; dstore[u] = data;
    for (int k = 0; k <= L + 1; k++) begin
      if (scramble && k == 1 && L > 0) begin
        iaddr[u] = $urandom; daddr[u] = $urandom; dstore[u] = $urandom;
      end
      if (collide && k == L + 1) begin
        bdw[u] = 1'b1; bda[u] = addr; bdd[u] = bdata;
      end
      @(negedge clk);
      chk("ramstate", 32'(rs[u]), rs_exp(k, L));
      chk(isd ? "dwait" : "iwait", 32'(isd ? dwait[u] : iwait[u]), 32'(k <= L));
      if (k == L + 1 && !wen) begin
        chk(isd ? "dload" : "iload", isd ? dload[u] : iload[u], mdl[u][idx(addr)]);
        if (isd) last_d[u] = mdl[u][idx(addr)];
        else     last_i[u] = mdl[u][idx(addr)];
      end
      step();
    end
    if (wen) mdl[u][idx(addr)] = collide ? bdata : data;
    clr(u);
  endtask

  task automatic idle_chk(input int u);
    @(negedge clk);
    chk("idle_rs", 32'(rs[u]), 32'(FREE));
    chk("idle_iwait", 32'(iwait[u]), 32'd0);
    chk("idle_dwait", 32'(dwait[u]), 32'd0);
    chk("hold_iload", iload[u], last_i[u]);
    chk("hold_dload", dload[u], last_d[u]);
    step();
  endtask

  // kind 0: read+write conflict, 1: misaligned dcache, 2: misaligned icache.
  task automatic err_txn(input int u, input int kind);
    int h = $urandom_range(1, 3);
    word_t a = $urandom & 32'hFFFF_FFFC;
    bit w = $urandom_range(0, 1);
    if (kind == 0) begin dren[u] = 1'b1; dwen[u] = 1'b1; daddr[u] = a; end
    else if (kind == 1) begin
      dren[u] = !w; dwen[u] = w; daddr[u] = a | 32'($urandom_range(1, 3));
    end else begin iren[u] = 1'b1; iaddr[u] = a | 32'($urandom_range(1, 3)); end
    dstore[u] = $urandom;
    for (int k = 0; k <= h; k++) begin
      @(negedge clk);
      chk("err_rs", 32'(rs[u]), (k == 0) ? 32'(FREE) : 32'(ERROR));
      if (kind == 2 && k == 0) chk("err_iwait", 32'(iwait[u]), 32'd1);
      else                     chk("err_dwait", 32'(dwait[u]), 32'd1);
      step();
    end
    clr(u);
    @(negedge clk);
    chk("err_drop_rs", 32'(rs[u]), 32'(ERROR));
    chk("err_drop_dwait", 32'(dwait[u]), 32'd1);
    step();
    @(negedge clk);
    chk("err_exit_rs", 32'(rs[u]), 32'(FREE));
    chk("err_exit_dwait", 32'(dwait[u]), 32'd0);
    step();
    txn(u, 1'b1, 1'b0, a, 32'd0, 1'b0, 1'b0, 32'd0);
  endtask

  // icache and dcache reads overlapping; off=0 means both in the same cycle,
  // otherwise the dcache request arrives off cycles into the icache access.
  task automatic pair(input int u, input int off);
    int L = lat_of(u);
    bit dfirst = (off == 0);
    word_t ia = $urandom & 32'hFFFF_FFFC;
    word_t da = $urandom & 32'hFFFF_FFFC;
    int last = 2 * L + 3;
    iren[u] = 1'b1; iaddr[u] = ia;
    if (dfirst) begin dren[u] = 1'b1; daddr[u] = da; end
    for (int k = 0; k <= last; k++) begin
      int pos = (k <= L + 1) ? k : k - (L + 2);
      if (!dfirst && k == off) begin dren[u] = 1'b1; daddr[u] = da; end
      @(negedge clk);
      chk("pair_rs", 32'(rs[u]), rs_exp(pos, L));
      if (dfirst) begin
        chk("pair_dwait", 32'(dwait[u]), 32'(k <= L));
        chk("pair_iwait", 32'(iwait[u]), 32'(k != last));
      end else begin
        chk("pair_iwait", 32'(iwait[u]), 32'(k <= L));
        chk("pair_dwait", 32'(dwait[u]), 32'(k >= off && k != last));
      end
      if (k == L + 1 || k == last) begin
        if (dfirst == (k == L + 1)) begin
          chk("pair_dload", dload[u], mdl[u][idx(da)]);
          last_d[u] = mdl[u][idx(da)];
        end else begin
          chk("pair_iload", iload[u], mdl[u][idx(ia)]);
          last_i[u] = mdl[u][idx(ia)];
        end
      end
      step();
      if (k == L + 1) begin
        if (dfirst) dren[u] = 1'b0;
        else        iren[u] = 1'b0;
      end
    end
    clr(u);
  endtask

  // Request dropped (abort) or reset pulsed part way through; no write lands.
  task automatic cut(input int u, input bit do_rst);
    int L = lat_of(u);
    int j = do_rst ? $urandom_range(1, L + 1) : $urandom_range(1, L);
    bit isd = $urandom_range(0, 1);
    bit wen = isd & $urandom_range(0, 1);
    word_t a = $urandom & 32'hFFFF_FFFC;
    iren[u] = !isd; dren[u] = isd & !wen; dwen[u] = isd & wen;
    iaddr[u] = a; daddr[u] = a; dstore[u] = ~mdl[u][idx(a)];
    for (int k = 0; k < j; k++) begin
      @(negedge clk);
      chk("cut_rs", 32'(rs[u]), rs_exp(k, L));
      chk("cut_wait", 32'(isd ? dwait[u] : iwait[u]), 32'd1);
      step();
    end
    clr(u);
    rst[u] = do_rst;
    @(negedge clk);
    chk("cut_drop_rs", 32'(rs[u]), rs_exp(j, L));
    chk("cut_drop_wait", 32'(isd ? dwait[u] : iwait[u]), 32'd0);
    step();
    rst[u] = 1'b0;
    if (do_rst) begin last_i[u] = '0; last_d[u] = '0; end
    idle_chk(u);
    txn(u, 1'b1, 1'b0, a, 32'd0, 1'b0, 1'b0, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation still running, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int u = 0; u < 2; u++) begin
      clr(u); rst[u] = 1'b1;
      iaddr[u] = '0; daddr[u] = '0; dstore[u] = '0; bda[u] = '0; bdd[u] = '0;
      last_i[u] = '0; last_d[u] = '0;
    end
    step(); step();
    for (int u = 0; u < 2; u++) rst[u] = 1'b0;
    for (int u = 0; u < 2; u++) idle_chk(u);

    // Preload both arrays through the backdoor.
    for (int i = 0; i < 1024; i++) begin
      for (int u = 0; u < 2; u++) begin
        bdw[u] = 1'b1; bda[u] = 32'(i * 4); bdd[u] = $urandom;
        mdl[u][i] = bdd[u];
      end
      step();
    end
    for (int u = 0; u < 2; u++) bdw[u] = 1'b0;

    // Directed scenarios.
    bd_write(0, 32'h40, 32'hDEADBEEF);
    txn(0, 1'b0, 1'b0, 32'h40, 32'd0, 1'b0, 1'b0, 32'd0);
    txn(0, 1'b1, 1'b1, 32'h80, 32'h12345678, 1'b0, 1'b0, 32'd0);
    txn(0, 1'b1, 1'b0, 32'h80, 32'd0, 1'b0, 1'b0, 32'd0);
    pair(0, 0);
    err_txn(0, 0);
    cut(0, 1'b1);
    cut(0, 1'b0);
    txn(1, 1'b1, 1'b0, 32'h1000, 32'd0, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 4; i++)
      txn(1, 1'b1, 1'b0, 32'(i * 4), 32'd0, 1'b0, 1'b0, 32'd0);
    txn(0, 1'b1, 1'b1, 32'h200, 32'h1111_2222, 1'b0, 1'b1, 32'h3333_4444);
    txn(0, 1'b1, 1'b0, 32'h200, 32'd0, 1'b0, 1'b0, 32'd0);

    // Random mix over both instances.
    for (int it = 0; it < 400; it++) begin
      int u = $urandom_range(0, 1);
      int L = lat_of(u);
      int op = $urandom_range(0, 9);
      word_t a = $urandom & 32'hFFFF_FFFC;
      bit sc = $urandom_range(0, 1);
      case (op)
        0, 1: txn(u, 1'b0, 1'b0, a, 32'd0, sc, 1'b0, 32'd0);
        2, 3: txn(u, 1'b1, 1'b0, a, 32'd0, sc, 1'b0, 32'd0);
        4, 5: txn(u, 1'b1, 1'b1, a, $urandom, sc, ($urandom_range(0, 3) == 0), $urandom);
        6:    err_txn(u, $urandom_range(0, 2));
        7:    pair(u, $urandom_range(0, L + 1));
        8:    if (u == 0) cut(0, 1'b0); else idle_chk(u);
        default: if (u == 0 && sc) cut(0, 1'b1); else idle_chk(u);
      endcase
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
